// File: rtl/riscv_pkg.sv
// Shared constants and helpers for the RISC-V pre-decode stage.
package riscv_pkg;

  localparam logic [31:0] INSTR_NOP  = 32'h0000_0013;
  localparam logic [6:0]  OPC_JAL    = 7'b110_1111;
  localparam logic [6:0]  OPC_BRANCH = 7'b110_0011;

  // Compressed quadrant 01 and its control-transfer funct3 codes
  localparam logic [1:0]  C_Q1   = 2'b01;
  localparam logic [2:0]  C_J    = 3'b101;
  localparam logic [2:0]  C_JAL  = 3'b001;
  localparam logic [2:0]  C_BEQZ = 3'b110;
  localparam logic [2:0]  C_BNEZ = 3'b111;

  // Only the two low opcode bits decide instruction length
  function automatic logic is_16bit(input logic [1:0] instr_lsb);
    return instr_lsb != 2'b11;
  endfunction

endpackage

// File: rtl/riscv_pd_imm.sv
// Static predictor: extracts the control-transfer immediate and applies
// the taken rule (jumps always, conditional branches only when backward).
module riscv_pd_imm
  import riscv_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int HAS_RVC = 0
) (
  input  logic [31:0]     instr,
  output logic            taken,
  output logic [XLEN-1:0] imm
);

  logic [2:0] c_f3;

  assign c_f3 = instr[15:13];

  // Decode opcode, build the sign-extended offset and the direction rule
  always_comb begin
    taken = 1'b0;
    imm   = '0;
    if (instr[6:0] == OPC_JAL) begin
      taken = 1'b1;
      imm   = {{(XLEN-20){instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
    end else if (instr[6:0] == OPC_BRANCH) begin
      taken = instr[31];
      imm   = {{(XLEN-12){instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
    end else if ((HAS_RVC != 0) && (instr[1:0] == C_Q1)) begin
      case (c_f3)
        C_J, C_JAL: begin
          // C.JAL only exists on RV32
          taken = (c_f3 == C_J) || (XLEN == 32);
          imm   = {{(XLEN-11){instr[12]}}, instr[8], instr[10:9], instr[6], instr[7],
                   instr[2], instr[11], instr[5:3], 1'b0};
        end
        C_BEQZ, C_BNEZ: begin
          taken = instr[12];
          imm   = {{(XLEN-8){instr[12]}}, instr[6:5], instr[2], instr[11:10],
                   instr[4:3], 1'b0};
        end
        default: begin
          taken = 1'b0;
          imm   = '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/riscv_pd.sv
// Pre-decode stage: same-cycle static branch prediction back to fetch and
// the PD->ID pipeline register with flush/stall handling.
module riscv_pd
  import riscv_pkg::*;
#(
  parameter int              XLEN           = 32,
  parameter logic [XLEN-1:0] PC_INIT        = 'h200,
  parameter int              INSTR_SIZE     = 32,
  parameter int              EXCEPTION_SIZE = 12,
  parameter int              HAS_RVC        = 0
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      id_stall,
  input  logic                      bu_flush,
  input  logic                      st_flush,
  input  logic                      du_flush,
  input  logic [XLEN-1:0]           if_pc,
  input  logic [INSTR_SIZE-1:0]     if_instr,
  input  logic                      if_bubble,
  input  logic [EXCEPTION_SIZE-1:0] if_exception,
  output logic                      branch_taken,
  output logic [XLEN-1:0]           branch_pc,
  output logic [XLEN-1:0]           pd_pc,
  output logic [INSTR_SIZE-1:0]     pd_instr,
  output logic                      pd_bubble,
  output logic [EXCEPTION_SIZE-1:0] pd_exception,
  output logic                      pd_predicted
);

  logic            flushes;
  logic            predict_ok;
  logic            rule_taken;
  logic [XLEN-1:0] imm;

  riscv_pd_imm #(
    .XLEN    (XLEN),
    .HAS_RVC (HAS_RVC)
  ) u_imm (
    .instr (if_instr[31:0]),
    .taken (rule_taken),
    .imm   (imm)
  );

  assign flushes    = bu_flush | st_flush | du_flush;
  assign predict_ok = ~if_bubble & ~|if_exception & ~flushes & ~id_stall & rstn;

  assign branch_taken = predict_ok & rule_taken;
  assign branch_pc    = if_pc + imm;

  // PD->ID register: reset, then flush over stall, then advance
  always_ff @(posedge clk) begin
    if (!rstn) begin
      pd_pc        <= PC_INIT;
      pd_instr     <= INSTR_SIZE'(INSTR_NOP);
      pd_bubble    <= 1'b1;
      pd_exception <= '0;
      pd_predicted <= 1'b0;
    end else if (flushes) begin
      pd_instr     <= INSTR_SIZE'(INSTR_NOP);
      pd_bubble    <= 1'b1;
      pd_exception <= '0;
      pd_predicted <= 1'b0;
    end else if (!id_stall) begin
      pd_pc        <= if_pc;
      pd_instr     <= is_16bit(if_instr[1:0]) ? {{(INSTR_SIZE-16){1'b0}}, if_instr[15:0]}
                                              : if_instr;
      pd_bubble    <= if_bubble;
      pd_exception <= if_exception;
      pd_predicted <= branch_taken;
    end
  end

endmodule

// File: tb/tb_riscv_pd.sv
// Scoreboard bench for riscv_pd: one instance with RVC prediction and one
// without, both driven identically and checked against a reference model.
module tb_riscv_pd;

  logic        clk = 1'b0;
  logic        rstn, id_stall, bu_flush, st_flush, du_flush;
  logic [31:0] if_pc, if_instr;
  logic        if_bubble;
  logic [11:0] if_exception;

  logic        bt1, bt0, bub1, bub0, prd1, prd0;
  logic [31:0] bpc1, bpc0, ppc1, ppc0, pin1, pin0;
  logic [11:0] pex1, pex0;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        bubble;
    logic [11:0] exc;
    logic        pred1;
    logic        pred0;
  } exp_t;

  exp_t q[$];
  exp_t m;

  always #5 clk = ~clk;

  riscv_pd #(.XLEN(32), .PC_INIT(32'h200), .INSTR_SIZE(32), .EXCEPTION_SIZE(12), .HAS_RVC(1)) dut_rvc (
    .clk(clk), .rstn(rstn), .id_stall(id_stall), .bu_flush(bu_flush), .st_flush(st_flush),
    .du_flush(du_flush), .if_pc(if_pc), .if_instr(if_instr), .if_bubble(if_bubble),
    .if_exception(if_exception), .branch_taken(bt1), .branch_pc(bpc1), .pd_pc(ppc1),
    .pd_instr(pin1), .pd_bubble(bub1), .pd_exception(pex1), .pd_predicted(prd1));

  riscv_pd #(.XLEN(32), .PC_INIT(32'h200), .INSTR_SIZE(32), .EXCEPTION_SIZE(12), .HAS_RVC(0)) dut_norvc (
    .clk(clk), .rstn(rstn), .id_stall(id_stall), .bu_flush(bu_flush), .st_flush(st_flush),
    .du_flush(du_flush), .if_pc(if_pc), .if_instr(if_instr), .if_bubble(if_bubble),
    .if_exception(if_exception), .branch_taken(bt0), .branch_pc(bpc0), .pd_pc(ppc0),
    .pd_instr(pin0), .pd_bubble(bub0), .pd_exception(pex0), .pd_predicted(prd0));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference predictor: offsets summed from weighted instruction fields
  function automatic void ref_predict(input logic [31:0] i, input bit rvc,
                                      output bit tk, output int off);
    tk  = 0;
    off = 0;
    if (i[6:0] == 7'h6F) begin
      tk  = 1;
      off = int'(i[30:21]) * 2 + int'(i[20]) * 2048 + int'(i[19:12]) * 4096
            - int'(i[31]) * 1048576;
    end else if (i[6:0] == 7'h63) begin
      tk  = i[31];
      off = int'(i[11:8]) * 2 + int'(i[30:25]) * 32 + int'(i[7]) * 2048
            - int'(i[31]) * 4096;
    end else if (rvc && i[1:0] == 2'b01) begin
      if (i[15:13] == 3'd5 || i[15:13] == 3'd1) begin
        tk  = 1;
        off = int'(i[5:3]) * 2 + int'(i[11]) * 16 + int'(i[2]) * 32 + int'(i[7]) * 64
              + int'(i[6]) * 128 + int'(i[10:9]) * 256 + int'(i[8]) * 1024
              - int'(i[12]) * 2048;
      end else if (i[15:13] == 3'd6 || i[15:13] == 3'd7) begin
        tk  = i[12];
        off = int'(i[4:3]) * 2 + int'(i[11:10]) * 8 + int'(i[2]) * 32
              + int'(i[6:5]) * 64 - int'(i[12]) * 256;
      end
    end
  endfunction

  // Apply one cycle of stimulus, check prediction, queue next register state
  task automatic step(input bit rn, input bit st, input bit bf, input bit sf, input bit df,
                      input logic [31:0] pc, input logic [31:0] ins, input bit bub,
                      input logic [11:0] exc);
    bit tk1, tk0, ok, fl;
    int off1, off0;
    @(negedge clk);
    rstn = rn; id_stall = st; bu_flush = bf; st_flush = sf; du_flush = df;
    if_pc = pc; if_instr = ins; if_bubble = bub; if_exception = exc;
    #1;
    fl = bf | sf | df;
    ok = rn && !st && !fl && !bub && (exc == 0);
    ref_predict(ins, 1'b1, tk1, off1);
    ref_predict(ins, 1'b0, tk0, off0);
    chk("taken_rvc", {31'd0, bt1}, {31'd0, ok & tk1});
    chk("taken_norvc", {31'd0, bt0}, {31'd0, ok & tk0});
    if (ok && tk1) chk("target_rvc", bpc1, pc + off1);
    if (ok && tk0) chk("target_norvc", bpc0, pc + off0);
    if (!rn) begin
      m.pc = 32'h200; m.instr = 32'h13; m.bubble = 1; m.exc = 0; m.pred1 = 0; m.pred0 = 0;
    end else if (fl) begin
      m.instr = 32'h13; m.bubble = 1; m.exc = 0; m.pred1 = 0; m.pred0 = 0;
    end else if (!st) begin
      m.pc     = pc;
      m.instr  = (ins[1:0] == 2'b11) ? ins : (ins & 32'h0000_FFFF);
      m.bubble = bub;
      m.exc    = exc;
      m.pred1  = ok & tk1;
      m.pred0  = ok & tk0;
    end
    q.push_back(m);
  endtask

  // Monitor: every edge the PD register presents a new state to compare
  initial begin
    forever begin
      exp_t e;
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("pd_pc", ppc1, e.pc);
        chk("pd_instr", pin1, e.instr);
        chk("pd_bubble", {31'd0, bub1}, {31'd0, e.bubble});
        chk("pd_exception", {20'd0, pex1}, {20'd0, e.exc});
        chk("pd_predicted_rvc", {31'd0, prd1}, {31'd0, e.pred1});
        chk("pd_pc_norvc", ppc0, e.pc);
        chk("pd_instr_norvc", pin0, e.instr);
        chk("pd_bubble_norvc", {31'd0, bub0}, {31'd0, e.bubble});
        chk("pd_predicted_norvc", {31'd0, prd0}, {31'd0, e.pred0});
      end
    end
  end

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 5))
      0: return {r[31:7], 7'h6F};
      1: return {r[31:15], 3'b000, r[11:7], 7'h63};
      2: return {r[31:16], 3'b101, r[12:2], 2'b01};
      3: return {r[31:16], 2'b11, r[13:2], 2'b01};
      4: return {r[31:16], 3'b001, r[12:2], 2'b01};
      default: return r;
    endcase
  endfunction

  initial begin
    rstn = 0; id_stall = 0; bu_flush = 0; st_flush = 0; du_flush = 0;
    if_pc = 0; if_instr = 32'h13; if_bubble = 1; if_exception = 0;
    m = '{pc: 32'h200, instr: 32'h13, bubble: 1, exc: 0, pred1: 0, pred0: 0};

    step(0, 0, 0, 0, 0, 32'h200, 32'h0100006F, 0, 0);
    step(0, 0, 0, 0, 0, 32'h200, 32'h0100006F, 0, 0);
    step(1, 0, 0, 0, 0, 32'h200, 32'h0100006F, 0, 0);
    step(1, 0, 0, 0, 0, 32'h300, 32'hFE000CE3, 0, 0);
    step(1, 0, 0, 0, 0, 32'h300, 32'h00000863, 0, 0);
    step(1, 1, 0, 0, 0, 32'h500, 32'h0100006F, 0, 0);
    step(1, 1, 0, 1, 0, 32'h500, 32'h0100006F, 0, 0);
    step(1, 0, 0, 0, 0, 32'h600, 32'h0100006F, 0, 12'h001);
    step(1, 0, 0, 0, 0, 32'h700, 32'h0100006F, 1, 0);
    step(1, 0, 0, 0, 0, 32'h400, 32'h1234A021, 0, 0);
    step(1, 0, 0, 0, 0, 32'hFFFF_FFF8, 32'h0100006F, 0, 0);
    step(1, 0, 1, 0, 0, 32'h800, 32'h0100006F, 0, 0);
    step(1, 0, 0, 0, 1, 32'h800, 32'h0100006F, 0, 0);

    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 31) != 0), ($urandom_range(0, 7) == 0), ($urandom_range(0, 11) == 0),
           ($urandom_range(0, 11) == 0), ($urandom_range(0, 11) == 0), $urandom & 32'hFFFF_FFFE,
           rand_instr(), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 7) == 0) ? 12'($urandom_range(1, 4095)) : 12'h000);
    end

    step(1, 0, 0, 0, 0, 32'h200, 32'h13, 1, 0);
    @(posedge clk);
    #2;
    chk("scoreboard_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/riscv_pd.md
Name: riscv_pd

Overview:
- Pre-decode stage, directly downstream of instruction fetch; consumes if_pc, if_instr, if_bubble and if_exception.
- Performs static branch prediction on the instruction leaving fetch. Returns branch_taken and branch_pc to fetch in the same cycle.
- Registers the instruction, PC and exception into the PD→ID pipeline register, with stall/flush handling.

Parameters:
XLEN, 32, data/address width
PC_INIT, 'h200, reset value of pd_pc
INSTR_SIZE, 32, instruction width
EXCEPTION_SIZE, 12, exception vector width
HAS_RVC, 0, 1 = predict compressed jumps/branches

Ports:
clk  input  1  clock
rstn  input  1  reset, synchronous, active-low
id_stall  input  1  ID stall; hold PD register
bu_flush  input  1  branch-unit flush
st_flush  input  1  state flush
du_flush  input  1  debug-unit flush
if_pc  input  XLEN  PC of if_instr
if_instr  input  INSTR_SIZE  instruction from fetch; 16-bit instr in [15:0]
if_bubble  input  1  if_instr invalid
if_exception  input  EXCEPTION_SIZE  fetch exception bits
branch_taken  output  1  predicted taken, to fetch (combinational)
branch_pc  output  XLEN  predicted target, to fetch (combinational)
pd_pc  output  XLEN  registered PC to ID
pd_instr  output  INSTR_SIZE  registered instruction to ID
pd_bubble  output  1  registered bubble to ID
pd_exception  output  EXCEPTION_SIZE  registered exception to ID
pd_predicted  output  1  registered: instr was predicted taken

Behaviour:
- Clocking and reset: one clock, clk. Reset rstn is synchronous and active-low; all state updates on posedge clk only.
- Reset values:
  - pd_pc=PC_INIT, pd_instr=INSTR_NOP (0x00000013), pd_bubble=1, pd_exception=0, pd_predicted=0.
  - branch_taken=0 whenever rstn=0.
- Flush (bu|st|du):
  - flushes = bu_flush|st_flush|du_flush.
  - Next edge: pd_bubble=1, pd_instr=INSTR_NOP, pd_exception=0, pd_predicted=0; pd_pc unchanged.
  - Flush has priority over id_stall.
- Stall: id_stall=1 and no flush -> all pd_* registers hold.
- Advance: no flush, no stall -> pd_pc<=if_pc, pd_instr<=if_instr, pd_bubble<=if_bubble, pd_exception<=if_exception, pd_predicted<=branch_taken.
  - 16-bit instruction (if_instr[1:0]!=2'b11): pd_instr<={16'h0000, if_instr[15:0]}.
- Prediction (combinational):
  - Qualifier: predict_ok = ~if_bubble & ~|if_exception & ~flushes & ~id_stall & rstn.
  - JAL (opcode 1101111): always taken; imm = sext{i[31],i[19:12],i[20],i[30:21],0}.
  - BRANCH (opcode 1100011): taken iff i[31]=1 (backward); imm = sext{i[31],i[7],i[30:25],i[11:8],0}.
  - JALR: never predicted.
  - HAS_RVC=1, quadrant 01:
    - C.J (f3=101): always taken; imm = sext{i[12],i[8],i[10:9],i[6],i[7],i[2],i[11],i[5:3],0}.
    - C.JAL (f3=001, XLEN==32 only): always taken; same immediate as C.J.
    - C.BEQZ/C.BNEZ (f3=110/111): taken iff i[12]=1; imm = sext{i[12],i[6:5],i[2],i[11:10],i[4:3],0}.
  - HAS_RVC=0: 16-bit encodings are never predicted.
  - branch_taken = predict_ok & taken_rule.
  - branch_pc = if_pc + imm, modulo 2^XLEN; wrap-around is permitted.
  - branch_pc is don't-care when branch_taken=0 and must be driven as if_pc + imm regardless.
- Latency: prediction 0 cycles; PD register 1 cycle.
- After a taken prediction, fetch flushes and delivers if_bubble=1, so no double prediction can occur. PD itself carries no extra state for this.

Decomposition:
- riscv_pkg: INSTR_NOP, OPC_JAL, OPC_BRANCH, RVC quadrant/funct3 constants (C_J, C_JAL, C_BEQZ, C_BNEZ), function is_16bit(instr).
- Sub-module riscv_pd_imm: purely combinational immediate extraction plus taken rule. Outputs taken and imm; parameters XLEN, HAS_RVC.
- riscv_pd contains the register stage and the adder.

Test Plan:
- Reset: rstn=0 for 2 cycles -> pd_bubble=1, pd_instr=0x00000013, pd_pc=0x200, branch_taken=0.
- JAL forward: if_pc=0x200, if_instr=0x0100006F -> branch_taken=1, branch_pc=0x210 same cycle; next cycle pd_pc=0x200, pd_predicted=1.
- Conditional direction:
  - if_pc=0x300, BEQ 0xFE000CE3 (−8) -> branch_taken=1, branch_pc=0x2F8.
  - BEQ 0x00000863 (+16) -> branch_taken=0; next cycle pd_predicted=0, pd_instr=0x00000863.
- Stall/flush:
  - id_stall=1 with JAL present -> branch_taken=0, pd_* hold.
  - st_flush=1 with id_stall=1 -> next cycle pd_bubble=1, pd_instr=0x00000013.
- Qualifiers: if_exception=0x001 with JAL -> branch_taken=0, pd_exception=0x001. if_bubble=1 with JAL -> branch_taken=0, pd_bubble=1.
- RVC: HAS_RVC=1, if_pc=0x400, if_instr[15:0]=0xA021 (C.J +8) -> branch_taken=1, branch_pc=0x408, pd_instr=0x0000A021. Same stimulus with HAS_RVC=0 -> branch_taken=0.
